// File: rtl/digit_serial_adder_if.sv
// +----------------------------------------------------------------------------+
// | digit_serial_adder_if : start/busy/done handshake and operand/result bus   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface digit_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SIGNED_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
`ifdef SIGNED_OVF_EN
    input  ovf,
`endif
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SIGNED_OVF_EN
    output ovf,
`endif
    output busy, done, sum, cout
  );
endinterface

`default_nettype wire

// File: rtl/digit_serial_adder.sv
// +----------------------------------------------------------------------------+
// | digit_serial_adder : WIDTH-bit A+B+cin, DIGIT bits per clock, one slice.    |
// | Optional macro SIGNED_OVF_EN adds the two's-complement overflow output.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  digit_serial_adder_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT:0]   w_digit;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  assign w_digit = {1'b0, r_a_sh[DIGIT-1:0]} + {1'b0, r_b_sh[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, r_carry};
  assign w_last  = (r_cnt == C_LAST);

  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[int'(r_cnt) * DIGIT +: DIGIT] = w_digit[DIGIT-1:0];
  end

`ifdef SIGNED_OVF_EN
  logic r_ovf;
  logic w_msb_cin;
  // Carry into the MSB is recovered from the MSB's own sum bit and operand bits.
  assign w_msb_cin = r_a_sh[DIGIT-1] ^ r_b_sh[DIGIT-1] ^ w_digit[DIGIT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_ovf <= w_msb_cin ^ w_digit[DIGIT];
    end
  end

  assign bus.ovf = r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b;
            r_carry <= bus.cin;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_a_sh  <= r_a_sh >> DIGIT;
          r_b_sh  <= r_b_sh >> DIGIT;
          r_carry <= w_digit[DIGIT];
          r_cnt   <= r_cnt + 1'b1;
          // Only the final digit publishes a result; partial sums stay internal.
          if (w_last) begin
            r_sum   <= w_acc_next;
            r_cout  <= w_digit[DIGIT];
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
// +----------------------------------------------------------------------------+
// | tb_digit_serial_adder : DIGIT = 4, 1 and 16 instances against one model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_digit_serial_adder;
  localparam int W  = 16;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [W-1:0] a, b;
  logic cin;

  logic [NI-1:0] busy_v, done_v, cout_v;
  logic [W-1:0]  sum_v [NI];
`ifdef SIGNED_OVF_EN
  logic [NI-1:0] ovf_v;
`endif

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int D = (gi == 0) ? 4 : (gi == 1) ? 1 : 16;
    digit_serial_adder_if #(.WIDTH(W)) bus ();
    assign bus.start = start;
    assign bus.a     = a;
    assign bus.b     = b;
    assign bus.cin   = cin;
    digit_serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    assign busy_v[gi] = bus.busy;
    assign done_v[gi] = bus.done;
    assign sum_v[gi]  = bus.sum;
    assign cout_v[gi] = bus.cout;
`ifdef SIGNED_OVF_EN
    assign ovf_v[gi]  = bus.ovf;
`endif
  end

  // Reference: each instance needs W/D edges after acceptance; result is plain A+B+cin.
  int          m_rem  [NI];
  logic [W:0]  m_cap  [NI];
  logic        m_done [NI];
  logic [W-1:0] m_sum [NI];
  logic        m_cout [NI];
`ifdef SIGNED_OVF_EN
  logic        m_capovf [NI];
  logic        m_ovf    [NI];
`endif

  int npass, ntotal, ndone;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;
  vec_t vecs [8];

  function automatic int nd(input int i);
    return (i == 0) ? 4 : (i == 1) ? 16 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      m_rem[i]  = 0;
      m_cap[i]  = '0;
      m_done[i] = 1'b0;
      m_sum[i]  = '0;
      m_cout[i] = 1'b0;
`ifdef SIGNED_OVF_EN
      m_capovf[i] = 1'b0;
      m_ovf[i]    = 1'b0;
`endif
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_clear();
    end else begin
      for (int i = 0; i < NI; i++) begin
        m_done[i] = 1'b0;
        if (m_rem[i] == 0) begin
          if (start) begin
            m_rem[i] = nd(i);
            m_cap[i] = {1'b0, a} + {1'b0, b} + 17'(cin);
`ifdef SIGNED_OVF_EN
            m_capovf[i] = (a[W-1] == b[W-1]) && (m_cap[i][W-1] != a[W-1]);
`endif
          end
        end else begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            m_done[i] = 1'b1;
            m_sum[i]  = m_cap[i][W-1:0];
            m_cout[i] = m_cap[i][W];
`ifdef SIGNED_OVF_EN
            m_ovf[i]  = m_capovf[i];
`endif
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("busy[n%0d]", nd(i)), 32'(busy_v[i]), 32'(m_rem[i] > 0));
      chk($sformatf("done[n%0d]", nd(i)), 32'(done_v[i]), 32'(m_done[i]));
      chk($sformatf("sum[n%0d]",  nd(i)), 32'(sum_v[i]),  32'(m_sum[i]));
      chk($sformatf("cout[n%0d]", nd(i)), 32'(cout_v[i]), 32'(m_cout[i]));
`ifdef SIGNED_OVF_EN
      chk($sformatf("ovf[n%0d]",  nd(i)), 32'(ovf_v[i]),  32'(m_ovf[i]));
`endif
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0};

    npass = 0; ntotal = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    model_clear();
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Directed vectors, applied to all three digit widths at once.
    for (int v = 0; v < 8; v++) begin
      a = vecs[v].a; b = vecs[v].b; cin = vecs[v].cin; start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (18) cyc();
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("vec%0d sum[n%0d]", v, nd(i)), 32'(sum_v[i]), 32'(vecs[v].sum));
        chk($sformatf("vec%0d cout[n%0d]", v, nd(i)), 32'(cout_v[i]), 32'(vecs[v].cout));
`ifdef SIGNED_OVF_EN
        chk($sformatf("vec%0d ovf[n%0d]", v, nd(i)), 32'(ovf_v[i]), 32'(vecs[v].ovf));
`endif
      end
    end

    // Start while busy is ignored.
    a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    a = 16'hAAAA; start = 1'b1;
    cyc();
    start = 1'b0; a = '0; b = '0;
    ndone = 0;
    repeat (18) begin
      cyc();
      if (done_v[0]) ndone++;
    end
    chk("ignored start sum", 32'(sum_v[0]), 32'h0002);
    chk("ignored start done count", 32'(ndone), 32'd1);

    // Asynchronous reset in the middle of an add.
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all();
    chk("reset busy", 32'(busy_v[0]), 32'd0);
    chk("reset sum", 32'(sum_v[0]), 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      cyc();
      if (done_v[0]) ndone++;
    end
    chk("no done after reset", 32'(ndone), 32'd0);
    a = 16'h1234; b = 16'h4321; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (18) cyc();
    chk("post-reset sum", 32'(sum_v[0]), 32'h5555);

    // Start held high with operands changing every cycle.
    start = 1'b1;
    repeat (50) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      cyc();
    end
    start = 1'b0;
    repeat (18) cyc();

    // Random traffic.
    repeat (400) begin
      start = ($urandom_range(0, 2) == 0);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      cyc();
    end
    start = 1'b0;
    repeat (18) cyc();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

`default_nettype wire
